// File: rtl/fsm_seq_monitor_pkg.sv
// Shared encodings for the three-state sequencer and its monitor.
// The sequencer imports the same package, so both sides agree on the state codes.
package fsm_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        S1      = 2'b01,
        S2      = 2'b10,
        ILLEGAL = 2'b11
    } state_e;

    typedef enum logic [1:0] {
        ERR_NONE  = 2'b00,
        ERR_ENC   = 2'b01,
        ERR_TRANS = 2'b10
    } err_e;

    // Legal moves are only the ring IDLE->S1->S2->IDLE plus waiting in IDLE
    function automatic logic is_legal_transition(state_e prev, state_e cur);
        case ({prev, cur})
            {IDLE, IDLE}, {IDLE, S1}, {S1, S2}, {S2, IDLE}: return 1'b1;
            default:                                        return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/fsm_seq_monitor_if.sv
// Observation and status bundle between the sequencer side and the monitor.
// Widths must match the CNT_W/DW_W of the attached fsm_seq_monitor.
interface fsm_seq_monitor_if #(
    parameter int CNT_W = 8,
    parameter int DW_W  = 8
);
    logic [1:0]       state;
    logic             clear;
    logic [CNT_W-1:0] cycle_count;
    logic [DW_W-1:0]  last_idle_dwell;
    logic             dwell_valid;
    logic             idle_timeout;
    logic             err_pulse;
    logic             err_sticky;
    logic [1:0]       err_code;

    modport master (
        output state, clear,
        input  cycle_count, last_idle_dwell, dwell_valid, idle_timeout,
               err_pulse, err_sticky, err_code
    );

    modport slave (
        input  state, clear,
        output cycle_count, last_idle_dwell, dwell_valid, idle_timeout,
               err_pulse, err_sticky, err_code
    );
endinterface

// File: rtl/fsm_seq_monitor_sat_counter.sv
// Saturating up-counter with a synchronous clear that dominates increment.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q
);
    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign q = cnt_q;
endmodule

// File: rtl/fsm_seq_monitor.sv
// Checks sampled sequencer states against the legal ring, counts completed
// sequences, measures IDLE dwell and flags a stuck-in-IDLE timeout.
module fsm_seq_monitor
    import fsm_pkg::*;
#(
    parameter int          CNT_W   = 8,
    parameter int          DW_W    = 8,
    parameter int unsigned TIMEOUT = 16
) (
    input logic              clk,
    input logic              reset,
    fsm_seq_monitor_if.slave bus
);
    state_e cur_state;
    state_e prev_state_q, prev_state_d;
    logic   enc_err, trans_err, any_err;
    logic   seq_done, idle_exit, is_idle;

    logic [CNT_W-1:0] cycle_count;
    logic [DW_W-1:0]  dwell_cnt;
    logic [DW_W-1:0]  last_dwell_q, last_dwell_d;
    logic             dwell_valid_q, dwell_valid_d;
    logic             err_pulse_q, err_pulse_d;
    logic             err_sticky_q, err_sticky_d;
    err_e             err_code_q, err_code_d;

    assign cur_state = state_e'(bus.state);

    // A pair that follows an illegal encoding is not judged as a transition
    always_comb begin
        enc_err   = (cur_state == ILLEGAL);
        trans_err = !enc_err && (prev_state_q != ILLEGAL) &&
                    !is_legal_transition(prev_state_q, cur_state);
        any_err   = enc_err || trans_err;
        seq_done  = (prev_state_q == S2) && (cur_state == IDLE);
        idle_exit = (prev_state_q == IDLE) && (cur_state == S1);
        is_idle   = (cur_state == IDLE);
    end

    sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (seq_done),
        .clr   (bus.clear),
        .q     (cycle_count)
    );

    sat_counter #(.W(DW_W)) u_dwell_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (is_idle),
        .clr   (!is_idle),
        .q     (dwell_cnt)
    );

    always_comb begin
        prev_state_d  = cur_state;
        last_dwell_d  = last_dwell_q;
        dwell_valid_d = idle_exit;
        err_pulse_d   = any_err;
        err_sticky_d  = err_sticky_q;
        err_code_d    = err_code_q;

        if (idle_exit) begin
            last_dwell_d = dwell_cnt;
        end

        // A new error beats a simultaneous clear and is recorded as the first one
        if (any_err) begin
            err_sticky_d = 1'b1;
            if (!err_sticky_q || bus.clear) begin
                err_code_d = enc_err ? ERR_ENC : ERR_TRANS;
            end
        end else if (bus.clear) begin
            err_sticky_d = 1'b0;
            err_code_d   = ERR_NONE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_state_q  <= IDLE;
            last_dwell_q  <= '0;
            dwell_valid_q <= 1'b0;
            err_pulse_q   <= 1'b0;
            err_sticky_q  <= 1'b0;
            err_code_q    <= ERR_NONE;
        end else begin
            prev_state_q  <= prev_state_d;
            last_dwell_q  <= last_dwell_d;
            dwell_valid_q <= dwell_valid_d;
            err_pulse_q   <= err_pulse_d;
            err_sticky_q  <= err_sticky_d;
            err_code_q    <= err_code_d;
        end
    end

    assign bus.cycle_count     = cycle_count;
    assign bus.last_idle_dwell = last_dwell_q;
    assign bus.dwell_valid     = dwell_valid_q;
    assign bus.idle_timeout    = (TIMEOUT != 0) && (32'(dwell_cnt) >= TIMEOUT);
    assign bus.err_pulse       = err_pulse_q;
    assign bus.err_sticky      = err_sticky_q;
    assign bus.err_code        = err_code_q;
endmodule

// File: tb/tb_fsm_seq_monitor.sv
// Directed bench for fsm_seq_monitor: each issued vector queues its expected
// registered outputs, and a monitor compares them after the sampling edge.
module tb_fsm_seq_monitor;
    import fsm_pkg::*;

    typedef struct {
        int         idx;
        logic [1:0] cc;
        logic [7:0] lid;
        logic       dv;
        logic       to;
        logic       ep;
        logic       es;
        logic [1:0] ec;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad   = 0;
    int   vec_idx = 0;
    exp_t exp_q[$];

    fsm_seq_monitor_if #(.CNT_W(2), .DW_W(8)) bus ();

    fsm_seq_monitor #(.CNT_W(2), .DW_W(8), .TIMEOUT(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic checkField(input string name, input int idx,
                              input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL v%0d %s got=%0d exp=%0d", idx, name, got, exp);
        end
    endtask

    task automatic checkOutput(input exp_t e);
        checkField("cycle_count",     e.idx, 32'(bus.cycle_count),     32'(e.cc));
        checkField("last_idle_dwell", e.idx, 32'(bus.last_idle_dwell), 32'(e.lid));
        checkField("dwell_valid",     e.idx, 32'(bus.dwell_valid),     32'(e.dv));
        checkField("idle_timeout",    e.idx, 32'(bus.idle_timeout),    32'(e.to));
        checkField("err_pulse",       e.idx, 32'(bus.err_pulse),       32'(e.ep));
        checkField("err_sticky",      e.idx, 32'(bus.err_sticky),      32'(e.es));
        checkField("err_code",        e.idx, 32'(bus.err_code),        32'(e.ec));
    endtask

    task automatic applyStimulus(input logic [1:0] s, input logic c, input logic r,
                                 input logic [1:0] cc, input logic [7:0] lid,
                                 input logic dv, input logic to, input logic ep,
                                 input logic es, input logic [1:0] ec);
        exp_t e;
        @(negedge clk);
        reset     = r;
        bus.state = s;
        bus.clear = c;
        e.idx = vec_idx;
        e.cc  = cc;
        e.lid = lid;
        e.dv  = dv;
        e.to  = to;
        e.ep  = ep;
        e.es  = es;
        e.ec  = ec;
        vec_idx++;
        exp_q.push_back(e);
    endtask

    // Monitor: outputs are registered, so compare 3 time units after the edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #3;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput(e);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        bus.state = IDLE;
        bus.clear = 1'b0;

        // reset, IDLE x3, S1, S2, IDLE
        applyStimulus(IDLE, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(IDLE, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(IDLE, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(IDLE, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(S1,   0, 0, 0, 3, 1, 0, 0, 0, 0);
        applyStimulus(S2,   0, 0, 0, 3, 0, 0, 0, 0, 0);
        applyStimulus(IDLE, 0, 0, 1, 3, 0, 0, 0, 0, 0);

        // illegal encoding, then S1 with no transition error
        applyStimulus(ILLEGAL, 0, 0, 1, 3, 0, 0, 1, 1, 1);
        applyStimulus(S1,      0, 0, 1, 3, 0, 0, 0, 1, 1);

        // clear, then IDLE->S2 and S2->S1; first code held, then clear again
        applyStimulus(S2,   1, 0, 0, 3, 0, 0, 0, 0, 0);
        applyStimulus(IDLE, 0, 0, 1, 3, 0, 0, 0, 0, 0);
        applyStimulus(S2,   0, 0, 1, 3, 0, 0, 1, 1, 2);
        applyStimulus(S1,   0, 0, 1, 3, 0, 0, 1, 1, 2);
        applyStimulus(S2,   1, 0, 0, 3, 0, 0, 0, 0, 0);

        // six IDLE samples, timeout after the fourth, then S1
        applyStimulus(IDLE, 0, 0, 1, 3, 0, 0, 0, 0, 0);
        applyStimulus(IDLE, 0, 0, 1, 3, 0, 0, 0, 0, 0);
        applyStimulus(IDLE, 0, 0, 1, 3, 0, 0, 0, 0, 0);
        applyStimulus(IDLE, 0, 0, 1, 3, 0, 1, 0, 0, 0);
        applyStimulus(IDLE, 0, 0, 1, 3, 0, 1, 0, 0, 0);
        applyStimulus(IDLE, 0, 0, 1, 3, 0, 1, 0, 0, 0);
        applyStimulus(S1,   0, 0, 1, 6, 1, 0, 0, 0, 0);

        // saturation of the 2-bit sequence counter
        applyStimulus(S2,   0, 0, 1, 6, 0, 0, 0, 0, 0);
        applyStimulus(IDLE, 0, 0, 2, 6, 0, 0, 0, 0, 0);
        applyStimulus(S1,   0, 0, 2, 1, 1, 0, 0, 0, 0);
        applyStimulus(S2,   0, 0, 2, 1, 0, 0, 0, 0, 0);
        applyStimulus(IDLE, 0, 0, 3, 1, 0, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(S1,   0, 0, 3, 1, 1, 0, 0, 0, 0);
            applyStimulus(S2,   0, 0, 3, 1, 0, 0, 0, 0, 0);
            applyStimulus(IDLE, 0, 0, 3, 1, 0, 0, 0, 0, 0);
        end

        // clear coinciding with S2->IDLE drops the increment
        applyStimulus(S1,   0, 0, 3, 1, 1, 0, 0, 0, 0);
        applyStimulus(S2,   0, 0, 3, 1, 0, 0, 0, 0, 0);
        applyStimulus(IDLE, 1, 0, 0, 1, 0, 0, 0, 0, 0);

        // build cycle_count=2 and stop in S1
        applyStimulus(S1,   0, 0, 0, 1, 1, 0, 0, 0, 0);
        applyStimulus(S2,   0, 0, 0, 1, 0, 0, 0, 0, 0);
        applyStimulus(IDLE, 0, 0, 1, 1, 0, 0, 0, 0, 0);
        applyStimulus(S1,   0, 0, 1, 1, 1, 0, 0, 0, 0);
        applyStimulus(S2,   0, 0, 1, 1, 0, 0, 0, 0, 0);
        applyStimulus(IDLE, 0, 0, 2, 1, 0, 0, 0, 0, 0);
        applyStimulus(S1,   0, 0, 2, 1, 1, 0, 0, 0, 0);

        // asynchronous reset mid-S1 must clear outputs before any edge
        @(negedge clk);
        reset     = 1'b1;
        bus.state = IDLE;
        #1;
        checkField("rst_cycle_count", -1, 32'(bus.cycle_count),     32'd0);
        checkField("rst_last_dwell",  -1, 32'(bus.last_idle_dwell), 32'd0);
        checkField("rst_dwell_valid", -1, 32'(bus.dwell_valid),     32'd0);
        checkField("rst_err_sticky",  -1, 32'(bus.err_sticky),      32'd0);

        applyStimulus(IDLE, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(IDLE, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(S1,   0, 0, 0, 1, 1, 0, 0, 0, 0);
        applyStimulus(S2,   0, 0, 0, 1, 0, 0, 0, 0, 0);
        applyStimulus(IDLE, 0, 0, 1, 1, 0, 0, 0, 0, 0);

        repeat (2) @(posedge clk);
        #4;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("[TB] FAIL queue_drain got=%0d exp=0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
